// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions used by the M-extension sequencer.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN:0]   acc,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN:0]   acc_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   rem_sh_s;
    logic [XLEN+1:0] diff_s;

    // Compute both step variants and pick the one the current op needs.
    always_comb begin
        sum_s    = acc + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        rem_sh_s = {acc[XLEN-1:0], lo[XLEN-1]};
        diff_s   = {1'b0, rem_sh_s} - {2'b00, opb};
        acc_nxt  = acc;
        lo_nxt   = lo;
        if (is_div) begin
            // diff_s MSB set means the trial subtraction borrowed: restore.
            if (diff_s[XLEN+1]) begin
                acc_nxt = rem_sh_s;
            end else begin
                acc_nxt = diff_s[XLEN:0];
            end
            lo_nxt = {lo[XLEN-2:0], ~diff_s[XLEN+1]};
        end else begin
            acc_nxt = {1'b0, sum_s[XLEN:1]};
            lo_nxt  = {sum_s[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: FSM, counter and operand/result registers
// around the one-bit-per-cycle muldiv_core step.
module muldiv_seq #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    import riscv_pkg::*;

    localparam int CW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
        if (en) begin
            return ~v + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    muldiv_state_e   state_r, state_nxt_s;
    muldiv_op_e      op_r, op_in_s;
    logic            sign_a_r, sign_b_r;
    logic [CW-1:0]   count_r;
    logic [XLEN:0]   acc_r, acc_nxt_s;
    logic [XLEN-1:0] lo_r, lo_nxt_s, opb_r;
    logic            done_r;
    logic [XLEN-1:0] result_r;

    logic            a_signed_s, b_signed_s, sa_in_s, sb_in_s;
    logic            div_zero_s, ovf_s, special_s, accept_s;
    logic [XLEN-1:0] special_res_s, fix_res_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;

    assign op_in_s  = muldiv_op_e'(op_i);
    assign accept_s = (state_r == IDLE) && start_i && !flush_i;
    assign stall_o  = accept_s || (state_r == CALC) || (state_r == FIX);
    assign done_o   = done_r;
    assign result_o = result_r;

    muldiv_core #(.XLEN(XLEN)) u_core (
        .is_div  (is_div_op(op_r)),
        .acc     (acc_r),
        .lo      (lo_r),
        .opb     (opb_r),
        .acc_nxt (acc_nxt_s),
        .lo_nxt  (lo_nxt_s)
    );

    // Decode the incoming op: operand signedness and the early-out special cases.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op_in_s)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            OP_MULHSU: a_signed_s = 1'b1;
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        sa_in_s    = a_signed_s && a_i[XLEN-1];
        sb_in_s    = b_signed_s && b_i[XLEN-1];
        div_zero_s = is_div_op(op_i) && (b_i == {XLEN{1'b0}});
        ovf_s      = (op_in_s == OP_DIV || op_in_s == OP_REM) &&
                     (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == {XLEN{1'b1}});
        special_s  = div_zero_s || ovf_s;
        // op_i[1] separates REM/REMU from DIV/DIVU.
        if (op_i[1]) begin
            special_res_s = div_zero_s ? a_i : {XLEN{1'b0}};
        end else begin
            special_res_s = div_zero_s ? {XLEN{1'b1}} : a_i;
        end
    end

    // Apply sign correction and select the architectural result.
    always_comb begin
        prod_s = {acc_r[XLEN-1:0], lo_r};
        if (sign_a_r ^ sign_b_r) begin
            prod_fix_s = ~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            prod_fix_s = prod_s;
        end
        case (op_r)
            OP_MUL:                       fix_res_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res_s = cond_neg(lo_r, sign_a_r ^ sign_b_r);
            default:                      fix_res_s = cond_neg(acc_r[XLEN-1:0], sign_a_r);
        endcase
    end

    // Next-state logic; a flush wins over everything.
    always_comb begin
        state_nxt_s = state_r;
        if (flush_i) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_nxt_s = special_s ? DONE : CALC;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CALC: begin
                    if (count_r == {CW{1'b0}}) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end
                FIX:     state_nxt_s = DONE;
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, iteration registers and registered result/done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r     <= OP_MUL;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            count_r  <= {CW{1'b0}};
            acc_r    <= {(XLEN+1){1'b0}};
            lo_r     <= {XLEN{1'b0}};
            opb_r    <= {XLEN{1'b0}};
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r     <= op_in_s;
                        sign_a_r <= sa_in_s;
                        sign_b_r <= sb_in_s;
                        count_r  <= CW'(XLEN-1);
                        acc_r    <= {(XLEN+1){1'b0}};
                        lo_r     <= cond_neg(a_i, sa_in_s);
                        opb_r    <= cond_neg(b_i, sb_in_s);
                    end
                end
                CALC: begin
                    acc_r   <= acc_nxt_s;
                    lo_r    <= lo_nxt_s;
                    count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                end
                default: begin
                end
            endcase
            done_r <= (state_nxt_s == DONE);
            if (state_nxt_s == DONE) begin
                result_r <= (state_r == IDLE) ? special_res_s : fix_res_s;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_muldiv_seq;

    logic        clk;
    logic        reset_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int total = 0;
    int bad   = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = sa * sb;          return p[31:0];  end
            3'd1: begin p = sa * sb;          return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;          return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Called at #1 after a posedge with the DUT idle; returns one cycle after DONE.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        int stall_cnt;
        cyc = 0;
        stall_cnt = 0;
        start_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        while (cyc < 100) begin
            #1;
            if (stall_o) stall_cnt++;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            cyc++;
            if (done_o) break;
        end
        chk($sformatf("latency op%0d", op), 32'(cyc), 32'(ref_latency(op, a, b)));
        chk($sformatf("stall_cycles op%0d", op), 32'(stall_cnt), 32'(ref_latency(op, a, b)));
        chk($sformatf("result op%0d a=%h b=%h", op, a, b), result_o, ref_result(op, a, b));
        #1;
        chk("stall_in_done", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done_o), 32'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          sel;
        bit          seen_done;
        reset_n = 1'b1;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 3'd0;
        a_i     = 32'd0;
        b_i     = 32'd0;
        #1 reset_n = 1'b0;
        #2;
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_stall", 32'(stall_o), 32'd0);

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        do_op(3'd1, 32'd7, 32'hFFFF_FFFD);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd5, 32'd100, 32'd7);
        do_op(3'd7, 32'd100, 32'd7);
        do_op(3'd5, 32'd5, 32'd0);
        do_op(3'd6, 32'd5, 32'd0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush a divide at T+10 and restart a multiply at T+12.
        start_i = 1'b1;
        op_i = 3'd4;
        a_i = 32'd1000;
        b_i = 32'd3;
        seen_done = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            if (done_o) seen_done = 1'b1;
        end
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        chk("stall_at_flush", 32'(stall_o), 32'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        if (done_o) seen_done = 1'b1;
        #1;
        chk("stall_after_flush", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        if (done_o) seen_done = 1'b1;
        chk("no_done_on_flush", 32'(seen_done), 32'd0);
        do_op(3'd0, 32'd3, 32'd4);

        // Flush and start together: op must not be accepted.
        start_i = 1'b1;
        flush_i = 1'b1;
        op_i = 3'd0;
        a_i = 32'd5;
        b_i = 32'd5;
        #1;
        chk("stall_start_flush", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("not_accepted", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of CALC.
        start_i = 1'b1;
        op_i = 3'd5;
        a_i = 32'd100;
        b_i = 32'd7;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        #1 reset_n = 1'b0;
        #1;
        chk("midreset_stall", 32'(stall_o), 32'd0);
        chk("midreset_done", 32'(done_o), 32'd0);
        chk("midreset_result", result_o, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(3'd5, 32'd9, 32'd3);

        // Random ops, biased toward the special cases now and then.
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            do_op(rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Sequencer and iterative datapath for RV32M multiply/divide, sitting beside the EX stage of the pipelined core. It accepts an M-extension op from EX and holds the pipeline through a stall request while it iterates one bit per cycle. It returns the result with a one-cycle done pulse and aborts cleanly on a branch/jump flush. Its stall output is ORed into StallF/StallD/StallE, and FlushE by hazard control.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start_i  in  1  valid M-op in EX this cycle
op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  in  XLEN  rs1 operand, forwarded
b_i  in  XLEN  rs2 operand, forwarded
flush_i  in  1  kill in-flight op (PCSrcE)
stall_o  out  1  hold F/D/E
done_o  out  1  result valid, one cycle
result_o  out  XLEN  result, valid when done_o=1

Behaviour:
- Reset (async, reset_n=0): state=IDLE; counters, operand and accumulator registers cleared; stall_o=0, done_o=0, result_o=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE transitions:
  - Sample start_i only in IDLE.
  - start_i=1 and flush_i=0: latch op, absolute operand values, and sign flags.
  - Special cases go directly to DONE:
    - divide by zero: DIV/DIVU -> all ones; REM/REMU -> a_i.
    - signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
  - All other ops go to CALC with count=XLEN-1.
- Sign handling: signed flags apply as follows.
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- CALC, multiply: unsigned shift-add on magnitudes into a 2*XLEN product register, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; remainder register is XLEN+1 bits.
- Leave CALC after the iteration with count=0, then go to FIX.
- FIX: conditional two's-complement negation.
  - Product: negate when sign(a)^sign(b) under the op's signedness.
  - Quotient: negate when sign(a)^sign(b).
  - Remainder: takes the sign of the dividend.
- Result select:
  - MUL: low XLEN bits of the product.
  - MULH*: high XLEN bits of the product.
  - DIV*: quotient.
  - REM*: remainder.
- DONE: result_o registered, done_o=1 for exactly one cycle, stall_o=0. The stalled instruction advances this cycle. Next state is IDLE unconditionally.
- stall_o (combinational):
  - 1 when (IDLE and start_i and !flush_i), or state is CALC or FIX.
  - 0 in DONE.
  - 0 in IDLE with no start.
- Latency:
  - Normal op accepted at cycle T: CALC T+1..T+32, FIX T+33, done_o at T+34. stall_o is high for 34 cycles (T..T+33).
  - Special case: done_o at T+1, stall_o high for 1 cycle.
- Flush: flush_i=1 in any state -> IDLE next cycle. done_o is suppressed, stall_o drops next cycle, and partial state is discarded. Flush and start in the same IDLE cycle: op is not accepted.
- Back-to-back ops: the next M-op reaches EX the cycle after DONE and is sampled in IDLE. There are no dead cycles beyond that.
- Reset mid-operation: immediate return to IDLE, outputs to reset values.
- result_o holds its last value outside DONE. Consumers must qualify it with done_o.

Decomposition:
- Shared package riscv_pkg:
  - muldiv_op_e enum (the 8 funct3 encodings);
  - muldiv_state_e enum (IDLE, CALC, FIX, DONE);
  - XLEN constant.
- One natural sub-module, muldiv_core: shift-add / restoring-divide step logic (pure combinational, one iteration). muldiv_seq owns the FSM, counter, and registers.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done_o at T+34, result 0xFFFFFFEB. stall_o high exactly 34 cycles. MULH of the same operands -> 0xFFFFFFFF.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD (-3). REM of the same -> 0xFFFFFFFF (-1). DIVU a=100, b=7 -> 14. REMU of the same -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF at T+1. REM a=5, b=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
- Start DIV, assert flush_i at T+10 -> stall_o low from T+11, no done_o pulse. A new MUL 3*4 at T+12 -> result 12 at T+46.
- Assert reset_n=0 mid-CALC -> stall_o/done_o/result_o go to 0 asynchronously. After release, a fresh DIVU 9/3 -> 3.
